// File: rtl/wl_ctrl_pkg.sv
// Shared types and helpers for the wordline pulse controller.
package wl_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRECH = 2'd1,
    WL_ON = 2'd2,
    RECOV = 2'd3
  } wl_state_e;

  // Width that holds every down-counter load value (PRE_CYC-1, PULSE_CYC-1).
  function automatic int cnt_width(input int pre_cyc, input int pulse_cyc);
    int m;
    m = (pre_cyc > pulse_cyc) ? pre_cyc : pulse_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/wl_addr_dec.sv
// One-cold wordline decoder; addresses at or above NUM_WL decode to all ones.
module wl_addr_dec
  import wl_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int NUM_WL = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [NUM_WL-1:0] wl
);

  always_comb begin
    wl = '1;
    for (int i = 0; i < NUM_WL; i++) begin
      if (en && (32'(addr) == i)) wl[i] = 1'b0;
    end
  end

endmodule

// File: rtl/wl_pulse_ctrl.sv
// Sequences bitline precharge, a timed active-low wordline pulse and recovery
// for one row access; all outputs except req_ready come straight from flops.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// PRECH | bitline precharge, PRE_CYC cycles
// WL_ON | selected wordline low, PULSE_CYC cycles
// RECOV | all wordlines high, done pulse
module wl_pulse_ctrl
  import wl_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int NUM_WL    = 64,
  parameter int PRE_CYC   = 2,
  parameter int PULSE_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              bl_prech,
  output logic [NUM_WL-1:0] wordline,
  output logic              done,
  output logic              addr_err
);

  localparam int CNT_W = cnt_width(PRE_CYC, PULSE_CYC);
  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  wl_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [NUM_WL-1:0] wl_dec;
  logic              addr_oor;

  assign req_ready = (state == IDLE);
  assign addr_oor  = (32'(addr_q) >= NUM_WL);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = PRECH;
          cnt_nxt   = PRE_LOAD;
          addr_nxt  = req_addr;
        end
      end
      PRECH: begin
        if (cnt == '0) begin
          state_nxt = WL_ON;
          cnt_nxt   = PULSE_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      WL_ON: begin
        if (cnt == '0) state_nxt = RECOV;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      RECOV:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decode from next state so the wordline flop changes on the same edge as the FSM.
  wl_addr_dec #(
    .ADDR_W (ADDR_W),
    .NUM_WL (NUM_WL)
  ) u_dec (
    .addr (addr_nxt),
    .en   (state_nxt == WL_ON),
    .wl   (wl_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wordline <= '1;
      bl_prech <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addr_q   <= addr_nxt;
      wordline <= wl_dec;
      bl_prech <= (state_nxt == PRECH);
      done     <= (state_nxt == RECOV);
      addr_err <= (state_nxt == RECOV) && addr_oor;
    end
  end

endmodule

// File: tb/tb_wl_pulse_ctrl.sv
// Directed bench for wl_pulse_ctrl: three parameterisations share clk/rst.
module tb_wl_pulse_ctrl;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   // instance a: defaults; b: NUM_WL=48; c: PRE_CYC=PULSE_CYC=1
   logic        val_a, rdy_a, bl_a, done_a, err_a;
   logic [5:0]  addr_a;
   logic [63:0] wl_a;
   logic        val_b, rdy_b, bl_b, done_b, err_b;
   logic [5:0]  addr_b;
   logic [47:0] wl_b;
   logic        val_c, rdy_c, bl_c, done_c, err_c;
   logic [5:0]  addr_c;
   logic [63:0] wl_c;

   int q_a[$];
   int lo_cnt = 0;
   int lo_idx = -1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   wl_pulse_ctrl u_a (
      .clk(clk), .rst(rst), .req_valid(val_a), .req_ready(rdy_a), .req_addr(addr_a),
      .bl_prech(bl_a), .wordline(wl_a), .done(done_a), .addr_err(err_a)
   );

   wl_pulse_ctrl #(.ADDR_W(6), .NUM_WL(48), .PRE_CYC(2), .PULSE_CYC(3)) u_b (
      .clk(clk), .rst(rst), .req_valid(val_b), .req_ready(rdy_b), .req_addr(addr_b),
      .bl_prech(bl_b), .wordline(wl_b), .done(done_b), .addr_err(err_b)
   );

   wl_pulse_ctrl #(.ADDR_W(6), .NUM_WL(64), .PRE_CYC(1), .PULSE_CYC(1)) u_c (
      .clk(clk), .rst(rst), .req_valid(val_c), .req_ready(rdy_c), .req_addr(addr_c),
      .bl_prech(bl_c), .wordline(wl_c), .done(done_c), .addr_err(err_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle expectations for cycle k after the accepting edge.
   task automatic chk_cyc(input string tag, input int k, input int pre, input int pul,
                          input logic bl, input logic [63:0] wl, input logic [63:0] wl_on,
                          input logic dn, input logic rdy, input logic err, input logic err_on);
      logic        e_bl, e_dn, e_rdy, e_err;
      logic [63:0] e_wl;
      e_bl  = (k >= 1) && (k <= pre);
      e_wl  = ((k > pre) && (k <= pre + pul)) ? wl_on : '1;
      e_dn  = (k == pre + pul + 1);
      e_rdy = (k > pre + pul + 1);
      e_err = e_dn && err_on;
      chk($sformatf("%s_k%0d_bl", tag, k), bl, e_bl);
      chk($sformatf("%s_k%0d_wl", tag, k), wl, e_wl);
      chk($sformatf("%s_k%0d_done", tag, k), dn, e_dn);
      chk($sformatf("%s_k%0d_rdy", tag, k), rdy, e_rdy);
      chk($sformatf("%s_k%0d_err", tag, k), err, e_err);
   endtask

   task automatic wait_rdy_a();
      int n = 0;
      while (!rdy_a && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("rdy_a_timeout", rdy_a, 1'b1);
   endtask

   // Scoreboard side for instance a: one-cold, no overlap, pulse length, address.
   always @(negedge clk) begin
      int exp_addr;
      if (rst) begin
         lo_cnt = 0;
         lo_idx = -1;
      end else begin
         if (wl_a !== '1) begin
            chk("mon_one_cold", $countones(~wl_a), 1);
            chk("mon_no_overlap", bl_a, 1'b0);
            for (int i = 0; i < 64; i++) if (!wl_a[i]) lo_idx = i;
            lo_cnt++;
         end
         if (done_a) begin
            chk("mon_sb_nonempty", (q_a.size() > 0), 1'b1);
            if (q_a.size() > 0) begin
               exp_addr = q_a.pop_front();
               chk("mon_addr", lo_idx, exp_addr);
            end
            chk("mon_pulse_len", lo_cnt, 3);
            chk("mon_err", err_a, 1'b0);
            lo_cnt = 0;
            lo_idx = -1;
         end
      end
   end

   initial begin
      int last;
      rst = 1'b1;
      val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
      addr_a = '0;  addr_b = '0;  addr_c = '0;

      @(negedge clk);
      chk("rst_wl_a", wl_a, {64{1'b1}});
      chk("rst_bl_a", bl_a, 1'b0);
      chk("rst_done_a", done_a, 1'b0);
      chk("rst_err_a", err_a, 1'b0);
      chk("rst_rdy_a", rdy_a, 1'b1);
      chk("rst_wl_b", wl_b, {48{1'b1}});
      chk("rst_rdy_b", rdy_b, 1'b1);
      chk("rst_wl_c", wl_c, {64{1'b1}});
      chk("rst_rdy_c", rdy_c, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      // single access to row 5
      addr_a = 6'd5;
      val_a  = 1'b1;
      q_a.push_back(5);
      chk("a5_rdy_k0", rdy_a, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) val_a = 1'b0;
         chk_cyc("a5", k, 2, 3, bl_a, wl_a, ~(64'd1 << 5), done_a, rdy_a, err_a, 1'b0);
      end

      // back-to-back held requests across all rows; address wiggles while busy
      addr_a = 6'd0;
      val_a  = 1'b1;
      last   = 0;
      for (int a = 0; a < 64; a++) begin
         wait_rdy_a();
         if (a > 0) chk($sformatf("sweep_spacing_%0d", a), cyc - last, 7);
         last = cyc;
         q_a.push_back(a);
         @(negedge clk);
         addr_a = 6'($urandom_range(0, 63));
         if (a == 63) val_a = 1'b0;
         @(negedge clk);
         addr_a = 6'(a + 1);
      end
      wait_rdy_a();
      @(negedge clk);
      chk("sweep_drained", q_a.size(), 0);

      // reset in the middle of the pulse to row 9
      addr_a = 6'd9;
      val_a  = 1'b1;
      q_a.push_back(9);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) val_a = 1'b0;
      end
      chk("abort_wl_before", wl_a, ~(64'd1 << 9));
      rst = 1'b1;
      @(negedge clk);
      chk("abort_wl", wl_a, {64{1'b1}});
      chk("abort_rdy", rdy_a, 1'b1);
      chk("abort_bl", bl_a, 1'b0);
      chk("abort_done", done_a, 1'b0);
      q_a.delete();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("abort_no_done_%0d", k), done_a, 1'b0);
      end
      addr_a = 6'd9;
      val_a  = 1'b1;
      q_a.push_back(9);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) val_a = 1'b0;
         chk_cyc("a9", k, 2, 3, bl_a, wl_a, ~(64'd1 << 9), done_a, rdy_a, err_a, 1'b0);
      end

      // out-of-range row on the 48-wordline instance
      addr_b = 6'd50;
      val_b  = 1'b1;
      chk("b50_rdy_k0", rdy_b, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) begin
            val_b  = 1'b0;
            addr_b = 6'd3;
         end
         chk_cyc("b50", k, 2, 3, bl_b, {16'hffff, wl_b}, {64{1'b1}}, done_b, rdy_b, err_b, 1'b1);
      end

      // minimum timing instance, top row
      addr_c = 6'd63;
      val_c  = 1'b1;
      chk("c63_rdy_k0", rdy_c, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) val_c = 1'b0;
         chk_cyc("c63", k, 1, 1, bl_c, wl_c, ~(64'd1 << 63), done_c, rdy_c, err_c, 1'b0);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
